// File: rtl/mw_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mw_add_seq_pkg
// Purpose  : Shared definitions for the multi-word sequential adder: the
//            operand-tracking FSM encoding and the word-counter width helper.
// Contents : state_e      - FIRST (next word is word 0) / MID (inside operand)
//            cnt_width()  - width of a counter able to hold 0..max_words
// Revision : 1.0 - initial release
// ============================================================================
package mw_add_seq_pkg;

    typedef enum logic [0:0] {
        ST_FIRST = 1'b0,
        ST_MID   = 1'b1
    } state_e;

    // Counter width for a given maximum word count: $clog2(max_words + 1).
    function automatic int cnt_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

    localparam int DEF_MAX_WORDS = 8;
    localparam int DEF_CNT_W     = $clog2(DEF_MAX_WORDS + 1);

endpackage
`default_nettype wire

// File: rtl/mw_add_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : mw_add_seq_adder
// Purpose  : Single-word combinational adder: sum_o = a_i + b_i + cin_i.
// Ports    : a_i, b_i [N-1:0] - operand words
//            cin_i            - carry-in
//            sum_o [N-1:0]    - sum word
//            cout_o           - carry-out
// Revision : 1.0 - initial release
// ============================================================================
module mw_add_seq_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};

endmodule
`default_nettype wire

// File: rtl/mw_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : mw_add_seq
// Purpose  : Streams multi-word operands (least-significant word first) and
//            emits their sum one word per cycle with a single output register
//            stage. Carry is chained between words; an operand ends on s_last
//            or when MAX_WORDS words have been accepted.
// Ports    : clk, rst_n (async, active-low)
//            s_valid/s_ready, s_a, s_b, s_cin, s_last  - input word stream
//            m_valid/m_ready, m_z, m_last, m_cout,
//            m_zero, m_trunc                         - result word stream
// Revision : 1.0 - initial release
// ============================================================================
module mw_add_seq #(
    parameter int N         = 32,
    parameter int MAX_WORDS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] s_a,
    input  logic [N-1:0] s_b,
    input  logic         s_cin,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_z,
    output logic         m_last,
    output logic         m_cout,
    output logic         m_zero,
    output logic         m_trunc
);
    import mw_add_seq_pkg::*;

    localparam int CNT_W = cnt_width(MAX_WORDS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               zacc_q, zacc_d;
    logic               m_valid_q, m_valid_d;
    logic [N-1:0]       m_z_q, m_z_d;
    logic               m_last_q, m_last_d;
    logic               m_cout_q, m_cout_d;
    logic               m_zero_q, m_zero_d;
    logic               m_trunc_q, m_trunc_d;

    logic               w_accept;
    logic               w_cin;
    logic [N-1:0]       w_sum;
    logic               w_cout;
    logic               w_cnt_max;
    logic               w_end;
    logic               w_zall;

    // The output register can take a new word whenever it is empty or being drained.
    assign s_ready  = !m_valid_q || m_ready;
    assign w_accept = s_valid && s_ready;

    // Word 0 takes the external carry-in; later words take the chained carry.
    assign w_cin = (state_q == ST_FIRST) ? s_cin : carry_q;

    mw_add_seq_adder #(
        .N (N)
    ) u_adder (
        .a_i    (s_a),
        .b_i    (s_b),
        .cin_i  (w_cin),
        .sum_o  (w_sum),
        .cout_o (w_cout)
    );

    // cnt_q holds words already accepted in this operand, so the current word
    // is the MAX_WORDS-th one when cnt_q equals MAX_WORDS-1.
    assign w_cnt_max = (cnt_q == CNT_W'(MAX_WORDS - 1));
    assign w_end     = s_last || w_cnt_max;

    // Running "all words zero" flag; word 0 starts a fresh accumulation.
    assign w_zall = (w_sum == '0) && ((state_q == ST_FIRST) || zacc_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        zacc_d    = zacc_q;
        m_valid_d = m_valid_q;
        m_z_d     = m_z_q;
        m_last_d  = m_last_q;
        m_cout_d  = m_cout_q;
        m_zero_d  = m_zero_q;
        m_trunc_d = m_trunc_q;

        if (w_accept) begin
            m_valid_d = 1'b1;
            m_z_d     = w_sum;
            m_last_d  = w_end;
            m_cout_d  = w_end && w_cout;
            m_zero_d  = w_end && w_zall;
            m_trunc_d = w_cnt_max && !s_last;
            if (w_end) begin
                state_d = ST_FIRST;
                cnt_d   = '0;
                carry_d = 1'b0;
                zacc_d  = 1'b0;
            end else begin
                state_d = ST_MID;
                cnt_d   = cnt_q + CNT_W'(1);
                carry_d = w_cout;
                zacc_d  = w_zall;
            end
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FIRST;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            zacc_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_z_q     <= '0;
            m_last_q  <= 1'b0;
            m_cout_q  <= 1'b0;
            m_zero_q  <= 1'b0;
            m_trunc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            zacc_q    <= zacc_d;
            m_valid_q <= m_valid_d;
            m_z_q     <= m_z_d;
            m_last_q  <= m_last_d;
            m_cout_q  <= m_cout_d;
            m_zero_q  <= m_zero_d;
            m_trunc_q <= m_trunc_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_z     = m_z_q;
    assign m_last  = m_last_q;
    assign m_cout  = m_cout_q;
    assign m_zero  = m_zero_q;
    assign m_trunc = m_trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_mw_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mw_add_seq
// Purpose  : Self-checking bench for mw_add_seq (N=32, MAX_WORDS=8) using
//            directed vectors and a big-integer reference for mixed streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mw_add_seq;

    localparam int N  = 32;
    localparam int MW = 8;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [N-1:0]  s_a;
    logic [N-1:0]  s_b;
    logic          s_cin;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [N-1:0]  m_z;
    logic          m_last;
    logic          m_cout;
    logic          m_zero;
    logic          m_trunc;

    typedef struct packed {
        logic         last;
        logic         cout;
        logic         zero;
        logic         trunc;
        logic [N-1:0] z;
    } rec_t;

    rec_t got_q[$];
    rec_t exp_q[$];

    int   n_checks = 0;
    int   n_pass   = 0;
    logic rnd_ready = 1'b0;

    mw_add_seq #(
        .N         (N),
        .MAX_WORDS (MW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_a     (s_a),
        .s_b     (s_b),
        .s_cin   (s_cin),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_z     (m_z),
        .m_last  (m_last),
        .m_cout  (m_cout),
        .m_zero  (m_zero),
        .m_trunc (m_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Random downstream stalls change only on the falling edge.
    always @(negedge clk) begin
        if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
    end

    // Capture every result transfer (sampled mid-cycle, before the rising edge).
    always @(negedge clk) begin
        rec_t r;
        #2;
        if (m_valid && m_ready) begin
            r.last  = m_last;
            r.cout  = m_cout;
            r.zero  = m_zero;
            r.trunc = m_trunc;
            r.z     = m_z;
            got_q.push_back(r);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic [N-1:0] z, input logic last, input logic cout,
                            input logic zero, input logic trunc);
        rec_t r;
        r.last = last; r.cout = cout; r.zero = zero; r.trunc = trunc; r.z = z;
        exp_q.push_back(r);
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic last);
        int t;
        s_a = a; s_b = b; s_cin = cin; s_last = last; s_valid = 1'b1;
        t = 0;
        #2;
        while (!s_ready && t < 1000) begin
            @(negedge clk); #2; t++;
        end
        if (t >= 1000) check("send_ready_timeout", {63'd0, s_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Wait for all expected words, allow time for spurious extras, then compare.
    task automatic finish_test(input string name);
        for (int i = 0; i < 1000 && got_q.size() < exp_q.size(); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({name, ".count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                string t;
                t = $sformatf("%s.w%0d", name, i);
                check({t, ".z"},    64'(got_q[i].z),    64'(exp_q[i].z));
                check({t, ".last"}, 64'(got_q[i].last), 64'(exp_q[i].last));
                check({t, ".cout"}, 64'(got_q[i].cout), 64'(exp_q[i].cout));
                if (exp_q[i].last) begin
                    check({t, ".zero"},  64'(got_q[i].zero),  64'(exp_q[i].zero));
                    check({t, ".trunc"}, 64'(got_q[i].trunc), 64'(exp_q[i].trunc));
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_last = 1'b0;
        m_ready = 1'b1;

        // ---------------- reset state ----------------
        #2;
        check("rst.m_valid", 64'(m_valid), 64'd0);
        check("rst.m_z",     64'(m_z),     64'd0);
        check("rst.m_last",  64'(m_last),  64'd0);
        check("rst.m_cout",  64'(m_cout),  64'd0);
        check("rst.m_zero",  64'(m_zero),  64'd0);
        check("rst.m_trunc", 64'(m_trunc), 64'd0);
        check("rst.s_ready", 64'(s_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("post_rst.s_ready", 64'(s_ready), 64'd1);

        // ---------------- single word wrap to zero ----------------
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        push_exp(32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        finish_test("single");

        // ---------------- 3-word carry ripple ----------------
        send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
        push_exp(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        finish_test("ripple");

        // ---------------- backpressure ----------------
        m_ready = 1'b0;
        send(32'd1, 32'd2, 1'b0, 1'b0);
        s_a = 32'd10; s_b = 32'd20; s_cin = 1'b0; s_last = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            check($sformatf("bp.s_ready%0d", i), 64'(s_ready), 64'd0);
            check($sformatf("bp.m_z%0d", i),     64'(m_z),     64'd3);
            @(negedge clk);
        end
        m_ready = 1'b1;
        send(32'd10, 32'd20, 1'b0, 1'b1);
        push_exp(32'd3,  1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(32'd30, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_test("bp");

        // ---------------- truncation at MAX_WORDS, 9th word is word 0 ----------------
        send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        for (int i = 1; i < MW; i++) send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        send(32'd5, 32'd6, 1'b0, 1'b1);
        for (int i = 0; i < MW - 1; i++) push_exp(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(32'h0,  1'b1, 1'b1, 1'b1, 1'b1);
        push_exp(32'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_test("trunc");

        // ---------------- reset mid-operand ----------------
        send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("midrst.m_valid", 64'(m_valid), 64'd0);
        check("midrst.m_z",     64'(m_z),     64'd0);
        check("midrst.m_last",  64'(m_last),  64'd0);
        check("midrst.m_cout",  64'(m_cout),  64'd0);
        check("midrst.s_ready", 64'(s_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'd7, 32'd8, 1'b0, 1'b1);
        push_exp(32'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(32'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(32'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_test("midrst");

        // ---------------- random streams vs big-integer reference ----------------
        rnd_ready = 1'b1;
        for (int op = 0; op < 6; op++) begin
            logic [N*MW:0] A, B, S, msk;
            logic [N-1:0]  wa, wb;
            logic          cin;
            int            len;
            len = (op == 0) ? MW : $urandom_range(1, MW);
            cin = 1'($urandom_range(0, 1));
            A = '0; B = '0;
            for (int w = 0; w < len; w++) begin
                wa = (op == 1) ? 32'hFFFF_FFFF : $urandom;
                wb = $urandom;
                A[w*N +: N] = wa;
                B[w*N +: N] = wb;
                send(wa, wb, (w == 0) ? cin : 1'b0, (w == len - 1));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            S   = A + B + {{(N*MW){1'b0}}, cin};
            msk = ({{(N*MW){1'b0}}, 1'b1} << (len * N)) - 1'b1;
            for (int w = 0; w < len; w++) begin
                if (w == len - 1)
                    push_exp(S[w*N +: N], 1'b1, S[len*N], ((S & msk) == '0), 1'b0);
                else
                    push_exp(S[w*N +: N], 1'b0, 1'b0, 1'b0, 1'b0);
            end
            finish_test($sformatf("rand%0d", op));
        end
        rnd_ready = 1'b0;
        m_ready   = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mw_add_seq.md
MW_ADD_SEQ -- requirements
Module: mw_add_seq

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning data word width in bits (power of two, >= 2).
REQ-002 The block SHALL have parameter MAX_WORDS, default 8, meaning the maximum number of words in one operand.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port s_valid, input, 1 bit: an input word pair is offered.
REQ-006 The block SHALL have port s_ready, output, 1 bit: the block accepts the word pair this cycle.
REQ-007 The block SHALL have ports s_a and s_b, input, N bits each: operand words, least-significant word first.
REQ-008 The block SHALL have port s_cin, input, 1 bit: carry-in, sampled only on the first word of an operand.
REQ-009 The block SHALL have port s_last, input, 1 bit: marks the most-significant (final) word of an operand.
REQ-010 The block SHALL have port m_valid, output, 1 bit: result word available.
REQ-011 The block SHALL have port m_ready, input, 1 bit: downstream accepts the result word.
REQ-012 The block SHALL have port m_z, output, N bits: sum word.
REQ-013 The block SHALL have port m_last, output, 1 bit: final word of the result.
REQ-014 The block SHALL have port m_cout, output, 1 bit: final carry-out, meaningful only when m_last=1.
REQ-015 The block SHALL have port m_zero, output, 1 bit: whole multi-word sum is zero, meaningful only when m_last=1.
REQ-016 The block SHALL have port m_trunc, output, 1 bit: operand was forcibly terminated at MAX_WORDS words, meaningful only when m_last=1.

Function
REQ-017 Handshakes: a transfer SHALL occur when valid and ready are both high at a clock edge; each output SHALL hold stable while m_valid=1 and m_ready=0.
REQ-018 FSM states SHALL be FIRST (next accepted word is word 0) and MID (inside an operand); reset state SHALL be FIRST.
REQ-019 Carry-in for word 0 SHALL be s_cin; for each later word it SHALL be the carry register holding the previous word's carry-out.
REQ-020 Each accepted word SHALL be summed as s_a + s_b + carry-in, producing N sum bits and 1 carry-out bit.
REQ-021 Latency: an accepted word SHALL appear on m_z/m_valid on the following cycle (one output register stage).
REQ-022 s_ready SHALL equal (!m_valid || m_ready), giving full throughput of one word per cycle.
REQ-023 A word counter SHALL count accepted words; on the word where s_last=1 or the count reaches MAX_WORDS, m_last SHALL be set, the FSM SHALL return to FIRST, and the counter and carry register SHALL clear.
REQ-024 m_trunc SHALL be 1 only when termination came from the counter reaching MAX_WORDS with s_last=0.
REQ-025 m_zero SHALL be the AND of per-word zero flags over all words of the operand, accumulated in a register and cleared at the operand end.
REQ-026 m_cout SHALL be the carry-out of the final word; on non-last words it SHALL be 0.
REQ-027 With s_valid=0 the state SHALL hold; back-to-back operands with no idle cycle SHALL be supported.

Reset
REQ-028 On rst_n=0, asynchronously: m_valid=0, m_z=0, m_last=0, m_cout=0, m_zero=0, m_trunc=0, carry=0, counter=0, FSM=FIRST.
REQ-029 Reset asserted mid-operand SHALL discard the partial operand; the first word accepted after reset SHALL be treated as word 0.
REQ-030 s_ready SHALL be 1 during and immediately after reset.

Structure
REQ-031 The FSM state encoding and the counter-width constant ($clog2(MAX_WORDS+1)) SHALL reside in a shared package.
REQ-032 Word addition SHALL use one instance of the existing adder sub-module (parameter N); no other arithmetic sub-module SHALL be used.

Verification
REQ-033 Single word, N=32: a=FFFFFFFF, b=00000001, cin=0, last=1 -> m_z=00000000, m_cout=1, m_zero=1, m_last=1.
REQ-034 Carry ripple, 3 words, all a words=FFFFFFFF, all b words=0, cin=1 -> m_z words 0,0,0, m_cout=1, m_zero=1.
REQ-035 Backpressure: m_ready=0 for 5 cycles mid-operand -> s_ready=0, m_z held stable, no word lost or duplicated.
REQ-036 Truncation, MAX_WORDS=8, s_last never asserted -> m_last=1 and m_trunc=1 on the 8th word; the 9th word is treated as word 0 using s_cin.
REQ-037 rst_n pulsed low after word 2 of a 4-word operand -> all outputs 0 at once; the next word uses s_cin, not the stale carry.
REQ-038 Random multi-word streams with random valid/ready stalls -> concatenated m_z plus m_cout equals a reference big-integer sum.
